// File: rtl/cache_stats_pkg.sv
// Shared definitions for the cache statistics readout path: FSM encoding,
// comm command-word field positions and data-record select codes.
package cache_stats_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int IDX_W           = 5;
  localparam int COMM_IDX_LSB    = 0;
  localparam int COMM_IDX_MSB    = 4;
  localparam int COMM_EN_BIT     = 24;
  localparam int DEFAULT_N_WORDS = 18;

  localparam logic [1:0] SEL_STATISTICS = 2'b00;
  localparam logic [1:0] SEL_SAMPLER    = 2'b01;
  localparam logic [1:0] SEL_TRACKER    = 2'b10;

endpackage

// File: rtl/cache_performance_reader.sv
// Sweeps the controller's comm register indices with counting frozen and
// streams each settled 32-bit return word out over valid/ready.
module cache_performance_reader
  import cache_stats_pkg::*;
#(
  parameter int N_WORDS       = DEFAULT_N_WORDS,
  parameter int SETTLE_CYCLES = 2,
  parameter int ENABLE_BIT    = COMM_EN_BIT
) (
  input  logic        clock_i,
  input  logic        resetn_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        run_i,
  input  logic [1:0]  select_i,
  output logic [31:0] comm_o,
  output logic [1:0]  select_data_record_o,
  input  logic [31:0] comm_i,
  input  logic        stall_i,
  output logic [31:0] data_o,
  output logic [4:0]  index_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  state_e           state_q;
  state_e           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_acc;
  logic             settle_tick;
  logic             capture;
  logic             xfer;

  assign start_acc   = (state_q == ST_IDLE) && start_i && !abort_i;
  assign settle_tick = (state_q == ST_WAIT) && !abort_i && !stall_i;
  assign capture     = settle_tick && (cnt_q == CNT_W'(1));
  assign xfer        = (state_q == ST_EMIT) && !abort_i && ready_i;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) state_d = ST_WAIT;
        ST_WAIT: if (capture) state_d = ST_EMIT;
        ST_EMIT: if (ready_i) state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_WAIT;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    valid_o = (state_q == ST_EMIT);
    done_o  = (state_q == ST_DONE);
  end

  // Counting is gated off for the whole sweep so both halves of every
  // 64-bit counter are read from the same frozen snapshot.
  always_comb begin
    comm_o = '0;
    if (busy_o) comm_o[COMM_IDX_MSB:COMM_IDX_LSB] = idx_q;
    comm_o[ENABLE_BIT] = run_i & ~busy_o & resetn_i;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      idx_q                <= '0;
      cnt_q                <= '0;
      select_data_record_o <= '0;
    end else if (start_acc) begin
      idx_q                <= '0;
      cnt_q                <= CNT_INIT;
      select_data_record_o <= select_i;
    end else if (settle_tick) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (xfer && (idx_q != LAST_IDX)) begin
      idx_q <= idx_q + IDX_W'(1);
      cnt_q <= CNT_INIT;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      data_o  <= '0;
      index_o <= '0;
    end else if (capture) begin
      data_o  <= comm_i;
      index_o <= idx_q;
    end
  end

endmodule
